// File: rtl/counter_mod_n.sv
// Run-gated up/down counter with programmable terminal value, load clamp,
// wrap or one-shot behaviour, registered terminal-count pulse and status.
//
//   state | meaning
//   IDLE  | count holds until i_run; entered on reset, clear or load
//   RUN   | counting while i_run=1, paused (holding) while i_run=0
//   DONE  | one-shot only: frozen at terminal value, i_run ignored
module counter_mod_n #(
   parameter int WIDTH   = 8,
   parameter int ONESHOT = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_run,
   input  logic             i_up,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_num,
   input  logic [WIDTH-1:0] i_max,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_tc,
   output logic             o_busy,
   output logic             o_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam bit ONE_SHOT = (ONESHOT != 0);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;
   logic             at_term;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
      end
   end

   // Up terminal uses >= so a count stranded above a lowered i_max still wraps/stops.
   assign at_term = i_up ? (cnt_q >= i_max) : (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tc_d    = 1'b0;
      if (i_clear) begin
         cnt_d   = '0;
         state_d = IDLE;
      end else if (i_load) begin
         cnt_d   = (i_num > i_max) ? i_max : i_num;
         state_d = IDLE;
      end else if (state_q != DONE && i_run) begin
         state_d = RUN;
         if (at_term) begin
            tc_d = 1'b1;
            if (ONE_SHOT) begin
               state_d = DONE;
            end else begin
               cnt_d = i_up ? '0 : i_max;
            end
         end else begin
            cnt_d = i_up ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
         end
      end
   end

   assign o_cnt  = cnt_q;
   assign o_tc   = tc_q;
   assign o_busy = (state_q == RUN);
   assign o_done = ONE_SHOT && (state_q == DONE);

endmodule
